// File: rtl/quadrilatero_sa_wb_buffer_if.sv
// Handshake bundle between the systolic-array result port, the writeback buffer and the RF write port.
// The buffer takes the slave view; the array/RF/consumer environment takes the master view.
interface quadrilatero_sa_wb_buffer_if #(
   parameter int MESH_WIDTH = 4,
   parameter int DATA_WIDTH = 32,
   parameter int N_REGS     = 8,
   parameter int DEPTH      = 2,
   parameter int ID_WIDTH   = 4
);
   localparam int RLEN = DATA_WIDTH * MESH_WIDTH;
   localparam int RW   = $clog2(N_REGS);
   localparam int ROWW = $clog2(MESH_WIDTH);
   localparam int CW   = $clog2(DEPTH + 1);

   logic [RW-1:0]       sa_waddr_i;
   logic [ROWW-1:0]     sa_wrowaddr_i;
   logic [RLEN-1:0]     sa_wdata_i;
   logic                sa_we_i;
   logic                sa_wlast_i;
   logic [ID_WIDTH-1:0] sa_id_i;
   logic                sa_wready_o;

   logic [RW-1:0]       rf_waddr_o;
   logic [ROWW-1:0]     rf_wrowaddr_o;
   logic [RLEN-1:0]     rf_wdata_o;
   logic                rf_we_o;
   logic                rf_wlast_o;
   logic                rf_wready_i;

   logic                done_o;
   logic [ID_WIDTH-1:0] done_id_o;
   logic                done_ack_i;
   logic [CW-1:0]       occupancy_o;
   logic                err_o;

   modport slave (
      input  sa_waddr_i, sa_wrowaddr_i, sa_wdata_i, sa_we_i, sa_wlast_i, sa_id_i,
      output sa_wready_o,
      output rf_waddr_o, rf_wrowaddr_o, rf_wdata_o, rf_we_o, rf_wlast_o,
      input  rf_wready_i,
      output done_o, done_id_o,
      input  done_ack_i,
      output occupancy_o, err_o
   );

   modport master (
      output sa_waddr_i, sa_wrowaddr_i, sa_wdata_i, sa_we_i, sa_wlast_i, sa_id_i,
      input  sa_wready_o,
      input  rf_waddr_o, rf_wrowaddr_o, rf_wdata_o, rf_we_o, rf_wlast_o,
      output rf_wready_i,
      input  done_o, done_id_o,
      output done_ack_i,
      input  occupancy_o, err_o
   );
endinterface

// File: rtl/quadrilatero_sa_wb_buffer.sv
// Result writeback buffer: queues systolic-array result rows and drains them in order to the RF,
// flagging tile completion and row-sequence errors. Define QUADRILATERO_WB_BYPASS_EN for 0-cycle bypass.
module quadrilatero_sa_wb_buffer #(
   parameter int MESH_WIDTH = 4,
   parameter int DATA_WIDTH = 32,
   parameter int N_REGS     = 8,
   parameter int DEPTH      = 2,
   parameter int ID_WIDTH   = 4
) (
   input logic                    clk_i,
   input logic                    rst_ni,
   quadrilatero_sa_wb_buffer_if.slave bus
);
   localparam int RLEN = DATA_WIDTH * MESH_WIDTH;
   localparam int RW   = $clog2(N_REGS);
   localparam int ROWW = $clog2(MESH_WIDTH);
   localparam int PW   = $clog2(DEPTH);
   localparam int CW   = $clog2(DEPTH + 1);

   localparam logic [ROWW-1:0] ROW_LAST = ROWW'(MESH_WIDTH - 1);
   localparam logic [CW-1:0]   CNT_FULL = CW'(DEPTH);
   localparam logic [CW-1:0]   CNT_ONE  = CW'(1);
   localparam logic [PW-1:0]   PTR_ONE  = PW'(1);

   typedef struct packed {
      logic [RW-1:0]       waddr;
      logic [ROWW-1:0]     row;
      logic [RLEN-1:0]     data;
      logic                last;
      logic [ID_WIDTH-1:0] id;
   } entry_t;

   entry_t              r_mem [DEPTH];
   logic [PW-1:0]       r_wptr;
   logic [PW-1:0]       r_rptr;
   logic [CW-1:0]       r_count;
   logic [ROWW-1:0]     r_exp;
   logic                r_done;
   logic [ID_WIDTH-1:0] r_done_id;
   logic                r_err;

   entry_t              w_in;
   entry_t              w_head;
   entry_t              w_rf;
   logic                w_rf_we;
   logic                w_full;
   logic                w_empty;
   logic                w_stall;
   logic                w_byp_sel;
   logic                w_byp_wr;
   logic                w_accept;
   logic                w_push;
   logic                w_pop;
   logic                w_done_evt;
   logic [ID_WIDTH-1:0] w_done_id;
   logic                w_seq_err;

   function automatic logic [ROWW-1:0] next_row(input logic [ROWW-1:0] cur);
      logic [ROWW-1:0] nxt;
      if (cur == ROW_LAST) begin
         nxt = '0;
      end else begin
         nxt = cur + ROWW'(1);
      end
      return nxt;
   endfunction

   assign w_in = '{waddr: bus.sa_waddr_i, row: bus.sa_wrowaddr_i, data: bus.sa_wdata_i,
                   last: bus.sa_wlast_i, id: bus.sa_id_i};
   assign w_head  = r_mem[r_rptr];
   assign w_full  = (r_count == CNT_FULL);
   assign w_empty = (r_count == '0);

   // Bypass selection: only an empty FIFO whose incoming row is not held back by a pending done.
   always_comb begin
`ifdef QUADRILATERO_WB_BYPASS_EN
      w_byp_sel = w_empty & ~(bus.sa_wlast_i & r_done & ~bus.done_ack_i);
`else
      w_byp_sel = 1'b0;
`endif
   end

   // RF-side drive: head entry normally, the incoming row when bypassing.
   always_comb begin
      w_rf    = w_head;
      w_rf_we = 1'b0;
      w_stall = w_head.last & r_done & ~bus.done_ack_i;
      if (w_byp_sel) begin
         w_rf    = w_in;
         w_rf_we = bus.sa_we_i;
      end else begin
         w_rf    = w_head;
         w_rf_we = ~w_empty & ~w_stall;
      end
   end

   // Handshake decode; a bypassed row that the RF takes immediately is never stored.
   always_comb begin
      w_accept   = bus.sa_we_i & ~w_full;
      w_byp_wr   = w_byp_sel & bus.sa_we_i & bus.rf_wready_i;
      w_push     = w_accept & ~w_byp_wr;
      w_pop      = ~w_byp_sel & w_rf_we & bus.rf_wready_i;
      w_done_evt = (w_pop & w_head.last) | (w_byp_wr & bus.sa_wlast_i);
      if (w_byp_wr) begin
         w_done_id = bus.sa_id_i;
      end else begin
         w_done_id = w_head.id;
      end
   end

   // Row-sequence check against the expected row of the tile in progress.
   always_comb begin
      w_seq_err = (bus.sa_wrowaddr_i != r_exp)
                | (bus.sa_wlast_i & (r_exp != ROW_LAST))
                | ((r_exp == ROW_LAST) & ~bus.sa_wlast_i);
   end

   // Entry storage.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
      end else if (w_push) begin
         r_mem[r_wptr] <= w_in;
      end
   end

   // Pointers wrap naturally since DEPTH is a power of two.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_push) begin
            r_wptr <= r_wptr + PTR_ONE;
         end
         if (w_pop) begin
            r_rptr <= r_rptr + PTR_ONE;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CNT_ONE;
            2'b01:   r_count <= r_count - CNT_ONE;
            default: r_count <= r_count;
         endcase
      end
   end

   // Expected-row counter and sticky sequence error, both advanced by every accepted row.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_exp <= '0;
         r_err <= 1'b0;
      end else if (w_accept) begin
         r_exp <= next_row(r_exp);
         r_err <= r_err | w_seq_err;
      end
   end

   // Completion flag: a new last-row write wins over a simultaneous acknowledge.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_done    <= 1'b0;
         r_done_id <= '0;
      end else if (w_done_evt) begin
         r_done    <= 1'b1;
         r_done_id <= w_done_id;
      end else if (bus.done_ack_i) begin
         r_done    <= 1'b0;
         r_done_id <= '0;
      end
   end

   assign bus.sa_wready_o   = ~w_full;
   assign bus.rf_waddr_o    = w_rf.waddr;
   assign bus.rf_wrowaddr_o = w_rf.row;
   assign bus.rf_wdata_o    = w_rf.data;
   assign bus.rf_wlast_o    = w_rf.last;
   assign bus.rf_we_o       = w_rf_we;
   assign bus.done_o        = r_done;
   assign bus.done_id_o     = r_done_id;
   assign bus.occupancy_o   = r_count;
   assign bus.err_o         = r_err;
endmodule

// File: tb/tb_quadrilatero_sa_wb_buffer.sv
// Directed self-checking bench for quadrilatero_sa_wb_buffer: ordering, backpressure, done stall,
// sequence error and reset; the bypass case runs only when QUADRILATERO_WB_BYPASS_EN is defined.
module tb_quadrilatero_sa_wb_buffer;
   localparam int RLEN = 128;

   logic clk;
   logic rst_n;
   int   n_cmp;
   int   n_err;

   quadrilatero_sa_wb_buffer_if #(.MESH_WIDTH(4), .DATA_WIDTH(32), .N_REGS(8), .DEPTH(2), .ID_WIDTH(4)) bus ();

   quadrilatero_sa_wb_buffer #(.MESH_WIDTH(4), .DATA_WIDTH(32), .N_REGS(8), .DEPTH(2), .ID_WIDTH(4)) dut (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .bus    (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [RLEN-1:0] obs, input logic [RLEN-1:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [RLEN-1:0] row_data(input int id, input int row);
      logic [RLEN-1:0] v;
      for (int e = 0; e < 4; e++) begin
         v[e*32 +: 32] = 32'hC0DE_0000 + 32'(id * 256 + row * 16 + e);
      end
      return v;
   endfunction

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic put(input int rg, input int row, input logic last, input int id);
      bus.sa_waddr_i    = 3'(rg);
      bus.sa_wrowaddr_i = 2'(row);
      bus.sa_wdata_i    = row_data(id, row);
      bus.sa_wlast_i    = last;
      bus.sa_id_i       = 4'(id);
      bus.sa_we_i       = 1'b1;
   endtask

   task automatic idle();
      bus.sa_we_i       = 1'b0;
      bus.sa_waddr_i    = 3'd0;
      bus.sa_wrowaddr_i = 2'd0;
      bus.sa_wdata_i    = '0;
      bus.sa_wlast_i    = 1'b0;
      bus.sa_id_i       = 4'd0;
   endtask

   task automatic check_row(input string tag, input int rg, input int row, input logic last, input int id);
      check_eq({tag, "_we"},   128'(bus.rf_we_o),       128'(1'b1));
      check_eq({tag, "_reg"},  128'(bus.rf_waddr_o),    128'(rg));
      check_eq({tag, "_row"},  128'(bus.rf_wrowaddr_o), 128'(row));
      check_eq({tag, "_last"}, 128'(bus.rf_wlast_o),    128'(last));
      check_eq({tag, "_data"}, bus.rf_wdata_o,          row_data(id, row));
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      rst_n = 1'b0;
      idle();
      bus.rf_wready_i = 1'b0;
      bus.done_ack_i  = 1'b0;
      #1;
      check_eq("rst_we",    128'(bus.rf_we_o),     128'(0));
      check_eq("rst_done",  128'(bus.done_o),      128'(0));
      check_eq("rst_occ",   128'(bus.occupancy_o), 128'(0));
      check_eq("rst_err",   128'(bus.err_o),       128'(0));
      check_eq("rst_wdata", bus.rf_wdata_o,        128'(0));
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      tick();

`ifdef QUADRILATERO_WB_BYPASS_EN
      // Bypass: empty FIFO and ready RF write the row in the same cycle without storing it.
      bus.rf_wready_i = 1'b1;
      put(2, 0, 1'b0, 9);
      #1;
      check_row("byp", 2, 0, 1'b0, 9);
      tick();
      check_eq("byp_occ", 128'(bus.occupancy_o), 128'(0));
      idle();
      tick();
      check_eq("byp_occ2", 128'(bus.occupancy_o), 128'(0));
      check_eq("byp_err",  128'(bus.err_o),       128'(0));
`else
      // Tile id5 on reg3, RF always ready: one row per cycle, done one cycle after row 3.
      bus.rf_wready_i = 1'b1;
      for (int k = 0; k < 4; k++) begin
         put(3, k, (k == 3), 5);
         tick();
         check_row($sformatf("t1_r%0d", k), 3, k, (k == 3), 5);
         check_eq($sformatf("t1_occ%0d", k), 128'(bus.occupancy_o), 128'(1));
      end
      check_eq("t1_done_early", 128'(bus.done_o), 128'(0));
      idle();
      tick();
      check_eq("t1_done",   128'(bus.done_o),      128'(1));
      check_eq("t1_doneid", 128'(bus.done_id_o),   128'(5));
      check_eq("t1_we_off", 128'(bus.rf_we_o),     128'(0));
      check_eq("t1_occ",    128'(bus.occupancy_o), 128'(0));

      // Tile id6 while done(id5) is pending: rows 0-2 flow, row 3 waits for the ack.
      for (int k = 0; k < 3; k++) begin
         put(3, k, 1'b0, 6);
         tick();
         check_row($sformatf("t3_r%0d", k), 3, k, 1'b0, 6);
      end
      put(3, 3, 1'b1, 6);
      tick();
      check_eq("t3_stall_we", 128'(bus.rf_we_o), 128'(0));
      idle();
      tick();
      check_eq("t3_stall_we2", 128'(bus.rf_we_o),     128'(0));
      check_eq("t3_stall_occ", 128'(bus.occupancy_o), 128'(1));
      check_eq("t3_old_id",    128'(bus.done_id_o),   128'(5));
      bus.done_ack_i = 1'b1;
      #1;
      check_row("t3_r3", 3, 3, 1'b1, 6);
      tick();
      bus.done_ack_i = 1'b0;
      check_eq("t3_done",   128'(bus.done_o),      128'(1));
      check_eq("t3_doneid", 128'(bus.done_id_o),   128'(6));
      check_eq("t3_occ",    128'(bus.occupancy_o), 128'(0));
      bus.done_ack_i = 1'b1;
      tick();
      bus.done_ack_i = 1'b0;
      check_eq("ack_done",   128'(bus.done_o),    128'(0));
      check_eq("ack_doneid", 128'(bus.done_id_o), 128'(0));

      // Backpressure: RF stalled for 10 cycles fills the FIFO; release drains in order.
      bus.rf_wready_i = 1'b0;
      put(1, 0, 1'b0, 7);
      tick();
      put(1, 1, 1'b0, 7);
      tick();
      put(1, 2, 1'b0, 7);
      for (int c = 0; c < 10; c++) begin
         tick();
         check_eq($sformatf("bp_occ%0d", c),  128'(bus.occupancy_o), 128'(2));
         check_eq($sformatf("bp_rdy%0d", c),  128'(bus.sa_wready_o), 128'(0));
         check_eq($sformatf("bp_data%0d", c), bus.rf_wdata_o,        row_data(7, 0));
      end
      check_eq("bp_row0", 128'(bus.rf_wrowaddr_o), 128'(0));
      bus.rf_wready_i = 1'b1;
      tick();
      check_row("bp_r1", 1, 1, 1'b0, 7);
      check_eq("bp_rdy_rel", 128'(bus.sa_wready_o), 128'(1));
      tick();
      check_row("bp_r2", 1, 2, 1'b0, 7);
      put(1, 3, 1'b1, 7);
      tick();
      check_row("bp_r3", 1, 3, 1'b1, 7);
      idle();
      tick();
      check_eq("bp_done",   128'(bus.done_o),      128'(1));
      check_eq("bp_doneid", 128'(bus.done_id_o),   128'(7));
      check_eq("bp_occ",    128'(bus.occupancy_o), 128'(0));
      check_eq("bp_err",    128'(bus.err_o),       128'(0));
      bus.done_ack_i = 1'b1;
      tick();
      bus.done_ack_i = 1'b0;

      // Out-of-sequence row 2 while row 0 is expected: sticky error, row still written.
      put(4, 2, 1'b0, 8);
      tick();
      check_eq("seq_err", 128'(bus.err_o), 128'(1));
      check_row("seq_row", 4, 2, 1'b0, 8);
      idle();
      repeat (3) tick();
      check_eq("seq_err_held", 128'(bus.err_o), 128'(1));

      // Reset with two rows queued and a done pending.
      put(5, 1, 1'b1, 10);
      tick();
      idle();
      tick();
      check_eq("pre_rst_done", 128'(bus.done_o), 128'(1));
      bus.rf_wready_i = 1'b0;
      put(5, 0, 1'b0, 11);
      tick();
      put(5, 1, 1'b0, 11);
      tick();
      idle();
      check_eq("pre_rst_occ", 128'(bus.occupancy_o), 128'(2));
      #2;
      rst_n = 1'b0;
      #1;
      check_eq("mid_rst_we",    128'(bus.rf_we_o),       128'(0));
      check_eq("mid_rst_data",  bus.rf_wdata_o,          128'(0));
      check_eq("mid_rst_reg",   128'(bus.rf_waddr_o),    128'(0));
      check_eq("mid_rst_row",   128'(bus.rf_wrowaddr_o), 128'(0));
      check_eq("mid_rst_last",  128'(bus.rf_wlast_o),    128'(0));
      check_eq("mid_rst_done",  128'(bus.done_o),        128'(0));
      check_eq("mid_rst_id",    128'(bus.done_id_o),     128'(0));
      check_eq("mid_rst_occ",   128'(bus.occupancy_o),   128'(0));
      check_eq("mid_rst_err",   128'(bus.err_o),         128'(0));
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      check_eq("post_rst_rdy", 128'(bus.sa_wready_o), 128'(1));
      check_eq("post_rst_occ", 128'(bus.occupancy_o), 128'(0));
      check_eq("post_rst_we",  128'(bus.rf_we_o),     128'(0));
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
